// File: rtl/id_stage_sb.sv
// Decode/issue stage: register file with same-cycle writeback bypass, per-register
// in-flight write scoreboard, RAW/structural stall, decode-time branch resolution.
module id_stage_sb #(
  parameter int DATA_W   = 16,
  parameter int NREGS    = 8,
  parameter int MAX_INFL = 3,
  parameter int ZERO_REG = 0,
  localparam int RW      = $clog2(NREGS),
  localparam int CW      = $clog2(MAX_INFL + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_pc_inc,
  input  logic [RW-1:0]     in_rs1,
  input  logic [RW-1:0]     in_rs2,
  input  logic [RW-1:0]     in_rd,
  input  logic              in_use1,
  input  logic              in_use2,
  input  logic              in_wr,
  input  logic [DATA_W-1:0] in_imm,
  input  logic [15:0]       in_ctrl,
  input  logic [1:0]        in_br,
  input  logic              wb_en,
  input  logic [RW-1:0]     wb_sel,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_rd1,
  output logic [DATA_W-1:0] out_rd2,
  output logic [DATA_W-1:0] out_imm,
  output logic [15:0]       out_ctrl,
  output logic [RW-1:0]     out_rd,
  output logic              out_wr,
  output logic              flush,
  output logic [DATA_W-1:0] redirect_pc,
  output logic              hazard
);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [CW-1:0]     cnt_q  [NREGS];
  logic [CW-1:0]     cnt_d  [NREGS];

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_rd1_q, out_rd1_d;
  logic [DATA_W-1:0] out_rd2_q, out_rd2_d;
  logic [DATA_W-1:0] out_imm_q, out_imm_d;
  logic [15:0]       out_ctrl_q, out_ctrl_d;
  logic [RW-1:0]     out_rd_q, out_rd_d;
  logic              out_wr_q, out_wr_d;

  logic [DATA_W-1:0] rd1_s, rd2_s, target_s;
  logic              raw_s, struct_s, hazard_s, ready_s, issue_s, taken_s, flush_s;
  logic [NREGS-1:0]  inc_s, dec_s;

  function automatic logic is_zero_reg(input logic [RW-1:0] sel);
    return (ZERO_REG != 0) && (sel == '0);
  endfunction

  function automatic logic [DATA_W-1:0] read_port(
    input logic [RW-1:0]     sel,
    input logic [DATA_W-1:0] rf_val,
    input logic              wen,
    input logic [RW-1:0]     wsel,
    input logic [DATA_W-1:0] wdata
  );
    logic [DATA_W-1:0] val;
    if (is_zero_reg(sel)) begin
      val = '0;
    end else if (wen && (wsel == sel)) begin
      val = wdata;
    end else begin
      val = rf_val;
    end
    return val;
  endfunction

  // A single outstanding write that retires this very cycle is covered by the bypass.
  function automatic logic src_stall(
    input logic          used,
    input logic [CW-1:0] cnt,
    input logic          wb_hit
  );
    return used && (cnt != '0) && !((cnt == CW'(1)) && wb_hit);
  endfunction

  always_comb begin
    rd1_s    = read_port(in_rs1, regs_q[in_rs1], wb_en, wb_sel, wb_data);
    rd2_s    = read_port(in_rs2, regs_q[in_rs2], wb_en, wb_sel, wb_data);
    raw_s    = src_stall(in_use1, cnt_q[in_rs1], wb_en && (wb_sel == in_rs1)) ||
               src_stall(in_use2, cnt_q[in_rs2], wb_en && (wb_sel == in_rs2));
    struct_s = in_wr && (cnt_q[in_rd] == CW'(MAX_INFL));
    hazard_s = in_valid && (raw_s || struct_s);
    ready_s  = !hazard_s && (!out_valid_q || out_ready);
    issue_s  = in_valid && ready_s;
  end

  always_comb begin
    taken_s  = 1'b0;
    target_s = in_pc_inc + in_imm;
    case (in_br)
      2'd1: begin
        taken_s  = (rd1_s == '0);
        target_s = in_pc_inc + in_imm;
      end
      2'd2: begin
        taken_s  = (rd1_s != '0);
        target_s = in_pc_inc + in_imm;
      end
      2'd3: begin
        taken_s  = 1'b1;
        target_s = rd1_s + in_imm;
      end
      default: begin
        taken_s  = 1'b0;
        target_s = in_pc_inc + in_imm;
      end
    endcase
    // A taken branch whose target is the fall-through needs no redirect.
    flush_s = !rst && issue_s && taken_s && (target_s != in_pc_inc);
  end

  assign hazard      = !rst && hazard_s;
  assign in_ready    = ready_s;
  assign flush       = flush_s;
  assign redirect_pc = flush_s ? target_s : '0;

  always_comb begin
    regs_d = regs_q;
    if (wb_en && !is_zero_reg(wb_sel)) begin
      regs_d[wb_sel] = wb_data;
    end else begin
      regs_d = regs_q;
    end
  end

  always_comb begin
    inc_s = '0;
    dec_s = '0;
    cnt_d = cnt_q;
    for (int r = 0; r < NREGS; r++) begin
      inc_s[r] = issue_s && in_wr && (in_rd == RW'(r)) && !is_zero_reg(RW'(r));
      dec_s[r] = wb_en && (wb_sel == RW'(r));
      if (inc_s[r] && dec_s[r]) begin
        cnt_d[r] = cnt_q[r];
      end else if (inc_s[r]) begin
        cnt_d[r] = cnt_q[r] + CW'(1);
      end else if (dec_s[r] && (cnt_q[r] != '0)) begin
        cnt_d[r] = cnt_q[r] - CW'(1);
      end else begin
        cnt_d[r] = cnt_q[r];
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_rd1_d   = out_rd1_q;
    out_rd2_d   = out_rd2_q;
    out_imm_d   = out_imm_q;
    out_ctrl_d  = out_ctrl_q;
    out_rd_d    = out_rd_q;
    out_wr_d    = out_wr_q;
    if (issue_s) begin
      out_valid_d = 1'b1;
      out_rd1_d   = rd1_s;
      out_rd2_d   = rd2_s;
      out_imm_d   = in_imm;
      out_ctrl_d  = in_ctrl;
      out_rd_d    = in_rd;
      out_wr_d    = in_wr;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin
        regs_q[r] <= '0;
        cnt_q[r]  <= '0;
      end
      out_valid_q <= 1'b0;
      out_rd1_q   <= '0;
      out_rd2_q   <= '0;
      out_imm_q   <= '0;
      out_ctrl_q  <= '0;
      out_rd_q    <= '0;
      out_wr_q    <= 1'b0;
    end else begin
      regs_q      <= regs_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_rd1_q   <= out_rd1_d;
      out_rd2_q   <= out_rd2_d;
      out_imm_q   <= out_imm_d;
      out_ctrl_q  <= out_ctrl_d;
      out_rd_q    <= out_rd_d;
      out_wr_q    <= out_wr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_rd1   = out_rd1_q;
  assign out_rd2   = out_rd2_q;
  assign out_imm   = out_imm_q;
  assign out_ctrl  = out_ctrl_q;
  assign out_rd    = out_rd_q;
  assign out_wr    = out_wr_q;

endmodule
